// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that sequences four requesters into one shared register.
// Each grant is held HOLD cycles, then the winner's word is loaded and acked.
module shared_reg_arbiter #(
  parameter int WIDTH = 8,
  parameter int HOLD  = 2
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] data,
  output logic [3:0]         grant,
  output logic [3:0]         ack,
  output logic [WIDTH-1:0]   q,
  output logic [1:0]         owner,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    WRITE
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [1:0]       owner_q, owner_d;
  logic [3:0]       ack_q, ack_d;
  logic [1:0]       pick;

  // First set request after the previous winner, wrapping back to it last.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    pick  = last_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    q_d     = q_q;
    owner_d = owner_q;
    ack_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          sel_d   = pick;
          cnt_d   = 8'(HOLD - 1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req[sel_q]) begin
          state_d = IDLE;
        end else if (cnt_q == 8'd0) begin
          q_d     = data[sel_q*WIDTH +: WIDTH];
          owner_d = sel_q;
          last_d  = sel_q;
          ack_d   = 4'b0001 << sel_q;
          state_d = WRITE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      last_q  <= 2'd3;
      q_q     <= '0;
      owner_q <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      q_q     <= q_d;
      owner_q <= owner_d;
      ack_q   <= ack_d;
    end
  end

  // Decoded from registered state only.
  assign grant = (state_q == GRANT) ? (4'b0001 << sel_q) : 4'b0000;
  assign busy  = (state_q != IDLE);
  assign ack   = ack_q;
  assign q     = q_q;
  assign owner = owner_q;

endmodule
